// File: rtl/text_blit_engine.sv
`default_nettype none
// ============================================================================
//  Module   : text_blit_engine
//  Purpose  : Renders a string of 6-bit character codes into the framebuffer.
//             For each character it derives the 8x8 glyph's sprite-sheet base
//             address, then streams the glyph one pixel at a time from the
//             sprite ROM to the framebuffer write port. Pixels that fall off
//             the framebuffer are clipped.
//  Ports    : clk, rst_n           clock / asynchronous active-low reset
//             start, len           render request and string length (clamped)
//             dest_x, dest_y       top-left of the first glyph
//             busy, done           status (done is a one-cycle pulse)
//             char_idx, char_code  string lookup (combinational reply)
//             sprite_addr/_data    sprite ROM read port (1-cycle latency)
//             fb_addr/_data/_we,   framebuffer ready/valid write port
//             fb_ready
//  Options  : TEXT_BLIT_TRANSPARENT_EN - when defined, palette index 0 pixels
//             are skipped (not written) so the background shows through.
//  Revision : 1.0 - initial release
// ============================================================================
module text_blit_engine #(
  parameter  int MAX_LEN   = 16,
  parameter  int FB_WIDTH  = 320,
  parameter  int FB_HEIGHT = 240,
  parameter  int PIX_W     = 4,
  localparam int CI_W      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       len,
  input  logic [9:0]       dest_x,
  input  logic [8:0]       dest_y,
  output logic             busy,
  output logic             done,
  output logic [CI_W-1:0]  char_idx,
  input  logic [5:0]       char_code,
  output logic [19:0]      sprite_addr,
  input  logic [PIX_W-1:0] sprite_data,
  output logic [19:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             fb_we,
  input  logic             fb_ready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHAR  = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Glyphs live in a 160-px-wide sheet starting at c_SHEET_BASE; each row of
  // eight glyphs spans 8 pixel rows, hence the 1280 stride.
  localparam logic [19:0] c_SHEET_BASE = 20'd10272;
  localparam logic [19:0] c_ROW_STRIDE = 20'd1280;
  localparam logic [19:0] c_SHEET_W    = 20'd160;
  localparam logic [4:0]  c_MAX_LEN    = 5'(MAX_LEN);
  localparam logic [5:0]  c_SPACE      = 6'd63;
  localparam logic [5:0]  c_LAST_GLYPH = 6'd35;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [4:0]       r_len;
  logic [9:0]       r_dest_x;
  logic [8:0]       r_dest_y;
  logic [CI_W-1:0]  r_ci;
  logic [2:0]       r_px;
  logic [2:0]       r_py;
  logic [19:0]      r_base;
  logic [PIX_W-1:0] r_pix;
  logic [19:0]      r_fb_addr;
  logic             r_skip;

  logic [4:0]       w_len_clamped;
  logic             w_is_space;
  logic [5:0]       w_code;
  logic [19:0]      w_base;
  logic             w_last;
  logic [10:0]      w_x;
  logic [10:0]      w_y;
  logic             w_clip;
  logic             w_skip;
  logic [19:0]      w_fb_lin;
  logic [19:0]      w_sprite_addr;
  logic             w_glyph_end;
  logic             w_pix_adv;

  assign w_len_clamped = (len > c_MAX_LEN) ? c_MAX_LEN : len;
  assign w_is_space    = (char_code == c_SPACE);
  // Codes outside the glyph set fall back to 'A' (code 0).
  assign w_code        = (char_code > c_LAST_GLYPH && !w_is_space) ? 6'd0 : char_code;
  assign w_base        = c_SHEET_BASE + 20'(w_code[5:3]) * c_ROW_STRIDE
                         + 20'({w_code[2:0], 3'b000});
  // r_len is at least 1 whenever a character is being processed.
  assign w_last        = (5'(r_ci) == (r_len - 5'd1));

  // 11-bit intermediates so a glyph hanging off the right/bottom edge is
  // detected instead of wrapping back into the visible area.
  assign w_x           = 11'(r_dest_x) + 11'({r_ci, 3'b000}) + 11'(r_px);
  assign w_y           = 11'(r_dest_y) + 11'(r_py);
  assign w_clip        = (w_x >= 11'(FB_WIDTH)) || (w_y >= 11'(FB_HEIGHT));
  assign w_fb_lin      = 20'(w_y) * 20'(FB_WIDTH) + 20'(w_x);
  assign w_sprite_addr = r_base + 20'(r_py) * c_SHEET_W + 20'(r_px);

`ifdef TEXT_BLIT_TRANSPARENT_EN
  assign w_skip        = w_clip || (sprite_data == '0);
`else
  assign w_skip        = w_clip;
`endif

  assign w_glyph_end   = (r_px == 3'd7) && (r_py == 3'd7);
  // A skipped pixel spends exactly one cycle in WRITE regardless of fb_ready.
  assign w_pix_adv     = r_skip || fb_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (w_len_clamped == 5'd0) ? ST_DONE : ST_CHAR;
        end
      end
      ST_CHAR: begin
        if (w_is_space) begin
          w_next = w_last ? ST_DONE : ST_CHAR;
        end else begin
          w_next = ST_ADDR;
        end
      end
      ST_ADDR:  w_next = ST_DATA;
      ST_DATA:  w_next = ST_WRITE;
      ST_WRITE: begin
        if (w_pix_adv) begin
          if (w_glyph_end) begin
            w_next = w_last ? ST_DONE : ST_CHAR;
          end else begin
            w_next = ST_ADDR;
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_dest_x  <= '0;
      r_dest_y  <= '0;
      r_ci      <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_base    <= '0;
      r_pix     <= '0;
      r_fb_addr <= '0;
      r_skip    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len    <= w_len_clamped;
            r_dest_x <= dest_x;
            r_dest_y <= dest_y;
            r_ci     <= '0;
          end
        end
        ST_CHAR: begin
          if (w_is_space) begin
            if (!w_last) begin
              r_ci <= r_ci + CI_W'(1);
            end
          end else begin
            r_base <= w_base;
            r_px   <= '0;
            r_py   <= '0;
          end
        end
        ST_DATA: begin
          r_pix     <= sprite_data;
          r_fb_addr <= w_fb_lin;
          r_skip    <= w_skip;
        end
        ST_WRITE: begin
          if (w_pix_adv) begin
            r_px <= r_px + 3'd1;
            if (r_px == 3'd7) begin
              r_py <= r_py + 3'd1;
            end
            if (w_glyph_end && !w_last) begin
              r_ci <= r_ci + CI_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    fb_we       = 1'b0;
    fb_addr     = '0;
    fb_data     = '0;
    sprite_addr = '0;
    char_idx    = r_ci;
    case (r_state)
      ST_CHAR: busy = 1'b1;
      ST_ADDR: begin
        busy        = 1'b1;
        sprite_addr = w_sprite_addr;
      end
      ST_DATA: busy = 1'b1;
      ST_WRITE: begin
        busy = 1'b1;
        if (!r_skip) begin
          fb_we   = 1'b1;
          fb_addr = r_fb_addr;
          fb_data = r_pix;
        end
      end
      ST_DONE: done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_text_blit_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_blit_engine
//  Purpose  : Self-checking bench for text_blit_engine. Expected framebuffer
//             writes are queued when a string is launched and compared with
//             the writes accepted on the framebuffer port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_text_blit_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic [9:0]  dest_x = '0;
  logic [8:0]  dest_y = '0;
  logic        fb_ready = 1'b1;
  logic        busy, done, fb_we;
  logic [3:0]  char_idx;
  logic [5:0]  char_code;
  logic [19:0] sprite_addr, fb_addr;
  logic [3:0]  sprite_data = '0;
  logic [3:0]  fb_data;
  logic [5:0]  char_mem [16];

  text_blit_engine #(
    .MAX_LEN(16), .FB_WIDTH(320), .FB_HEIGHT(240), .PIX_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .dest_x(dest_x), .dest_y(dest_y), .busy(busy), .done(done),
    .char_idx(char_idx), .char_code(char_code),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready)
  );

  always #5 clk = ~clk;

  assign char_code = char_mem[char_idx];

  function automatic logic [3:0] rom_pix(input logic [19:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16];
  endfunction

  // Sprite ROM: one-cycle read latency
  always @(posedge clk) sprite_data <= rom_pix(sprite_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side
  logic [23:0] obs_q[$];
  logic [19:0] sa_q[$];
  int          busy_rise = 0, done_cyc = 0, done_cnt = 0, stall_err = 0;
  logic        prev_busy = 1'b0, prev_stall = 1'b0;
  logic [23:0] prev_wr = '0;

  always @(negedge clk) begin
    if (fb_we && fb_ready) obs_q.push_back({fb_addr, fb_data});
    if (sprite_addr != '0) sa_q.push_back(sprite_addr);
    if (prev_stall && !(fb_we && ({fb_addr, fb_data} == prev_wr)))
      stall_err <= stall_err + 1;
    prev_stall <= fb_we && !fb_ready;
    prev_wr    <= {fb_addr, fb_data};
    if (busy && !prev_busy) busy_rise <= cyc;
    prev_busy  <= busy;
    if (done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  // Scoreboard
  logic [23:0] exp_q[$];
  int exp_busy, exp_first_sa, ob, sb, db, start_cyc;
  int n_pass = 0, n_checks = 0;

  task automatic launch(input int l, input int dx, input int dy);
    int lc, c, base, x, y, sa;
    bit first;
    exp_q.delete();
    exp_busy = 0;
    exp_first_sa = 0;
    first = 1'b1;
    lc = (l > 16) ? 16 : l;
    for (int i = 0; i < lc; i++) begin
      c = int'(char_mem[i]);
      if (c == 63) begin
        exp_busy += 1;
        continue;
      end
      exp_busy += 193;
      if (c > 35) c = 0;
      base = 10272 + (c / 8) * 1280 + (c % 8) * 8;
      if (first) begin
        exp_first_sa = base;
        first = 1'b0;
      end
      for (int py = 0; py < 8; py++) begin
        for (int px = 0; px < 8; px++) begin
          sa = base + py * 160 + px;
          x  = dx + 8 * i + px;
          y  = dy + py;
          if (x < 320 && y < 240)
            exp_q.push_back({20'(y * 320 + x), rom_pix(20'(sa))});
        end
      end
    end
    ob = obs_q.size();
    sb = sa_q.size();
    db = done_cnt;
    @(posedge clk); #1;
    len = 5'(l); dest_x = 10'(dx); dest_y = 9'(dy); start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_cnt != db) begin
        ok = 1'b1;
        break;
      end
    end
    fb_ready = 1'b1;
  endtask

  function automatic int seq_errs();
    int n_obs, e;
    n_obs = obs_q.size() - ob;
    e = (n_obs > exp_q.size()) ? n_obs - exp_q.size() : exp_q.size() - n_obs;
    for (int i = 0; i < n_obs && i < exp_q.size(); i++)
      if (obs_q[ob + i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, fb_we} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, fb_we});
    else n_pass++;
    n_checks++;
    if (fb_addr !== 20'd0 || fb_data !== 4'd0) $display("FAIL reset_fb: got %0d/%0d want 0/0", fb_addr, fb_data);
    else n_pass++;
    n_checks++;
    if (sprite_addr !== 20'd0 || char_idx !== 4'd0) $display("FAIL reset_addr: got %0d/%0d want 0/0", sprite_addr, char_idx);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_s();
    bit ok;
    logic [23:0] w;
    char_mem[0] = 6'd18;
    launch(1, 0, 0);
    wait_done(600, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL s_done_timeout: got no done want done");
    else n_pass++;
    n_checks++;
    if (sa_q.size() <= sb || sa_q[sb] !== 20'd12848) $display("FAIL s_first_sa: got %0d want 12848", (sa_q.size() > sb) ? sa_q[sb] : 0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() - ob !== 64) $display("FAIL s_count: got %0d want 64", obs_q.size() - ob);
    else n_pass++;
    n_checks++;
    if (seq_errs() !== 0) $display("FAIL s_sequence: got %0d errors want 0", seq_errs());
    else n_pass++;
    w = (obs_q.size() > ob + 9) ? obs_q[ob + 9] : '0;
    n_checks++;
    if (w[23:4] !== 20'd321) $display("FAIL s_write9_addr: got %0d want 321", w[23:4]);
    else n_pass++;
    n_checks++;
    if (done_cyc - busy_rise !== 193) $display("FAIL s_timing: got %0d want 193", done_cyc - busy_rise);
    else n_pass++;
  endtask

  task automatic test_spaces();
    bit ok;
    logic [23:0] w;
    char_mem[0] = 6'd63; char_mem[1] = 6'd26; char_mem[2] = 6'd63;
    launch(3, 100, 50);
    wait_done(800, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL sp_done_timeout: got no done want done");
    else n_pass++;
    n_checks++;
    if (sa_q.size() <= sb || sa_q[sb] !== 20'd14128) $display("FAIL sp_first_sa: got %0d want 14128", (sa_q.size() > sb) ? sa_q[sb] : 0);
    else n_pass++;
    w = (obs_q.size() > ob) ? obs_q[ob] : '0;
    n_checks++;
    if (w[23:4] !== 20'd16108) $display("FAIL sp_first_fb: got %0d want 16108", w[23:4]);
    else n_pass++;
    n_checks++;
    if (seq_errs() !== 0) $display("FAIL sp_sequence: got %0d errors want 0", seq_errs());
    else n_pass++;
    n_checks++;
    if (done_cyc - busy_rise !== 195) $display("FAIL sp_timing: got %0d want 195", done_cyc - busy_rise);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    bit ok;
    int se0;
    se0 = stall_err;
    char_mem[0] = 6'd5;
    launch(1, 20, 30);
    wait_done(3000, 1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL rr_done_timeout: got no done want done");
    else n_pass++;
    n_checks++;
    if (obs_q.size() - ob !== 64) $display("FAIL rr_count: got %0d want 64", obs_q.size() - ob);
    else n_pass++;
    n_checks++;
    if (seq_errs() !== 0) $display("FAIL rr_sequence: got %0d errors want 0", seq_errs());
    else n_pass++;
    n_checks++;
    if (stall_err - se0 !== 0) $display("FAIL rr_stall_stable: got %0d changes want 0", stall_err - se0);
    else n_pass++;
  endtask

  task automatic test_clip();
    bit ok;
    int diffs;
    logic [23:0] run0[$];
    char_mem[0] = 6'd0;
    launch(1, 316, 0);
    wait_done(600, 1'b0, ok);
    n_checks++;
    if (obs_q.size() - ob !== 32) $display("FAIL clip_count: got %0d want 32", obs_q.size() - ob);
    else n_pass++;
    n_checks++;
    if (seq_errs() !== 0) $display("FAIL clip_sequence: got %0d errors want 0", seq_errs());
    else n_pass++;
    n_checks++;
    if (done_cyc - busy_rise !== 193) $display("FAIL clip_timing: got %0d want 193", done_cyc - busy_rise);
    else n_pass++;
    for (int i = ob; i < obs_q.size(); i++) run0.push_back(obs_q[i]);
    char_mem[0] = 6'd40;
    launch(1, 316, 0);
    wait_done(600, 1'b0, ok);
    diffs = (obs_q.size() - ob == run0.size()) ? 0 : 1;
    for (int i = 0; i < run0.size() && ob + i < obs_q.size(); i++)
      if (obs_q[ob + i] !== run0[i]) diffs++;
    n_checks++;
    if (diffs !== 0) $display("FAIL clip_code40_as_0: got %0d differences want 0", diffs);
    else n_pass++;
  endtask

  task automatic test_len_edges();
    bit ok;
    int br0;
    br0 = busy_rise;
    launch(0, 5, 5);
    wait_done(20, 1'b0, ok);
    n_checks++;
    if (!ok || done_cyc !== start_cyc + 1) $display("FAIL len0_done: got cycle %0d want %0d", done_cyc, start_cyc + 1);
    else n_pass++;
    n_checks++;
    if (obs_q.size() - ob !== 0 || busy_rise !== br0) $display("FAIL len0_quiet: got %0d writes want 0", obs_q.size() - ob);
    else n_pass++;
    for (int i = 0; i < 16; i++) char_mem[i] = 6'd63;
    launch(31, 0, 0);
    wait_done(100, 1'b0, ok);
    n_checks++;
    if (!ok || done_cyc - busy_rise !== exp_busy) $display("FAIL len_clamp_timing: got %0d want %0d", done_cyc - busy_rise, exp_busy);
    else n_pass++;
  endtask

  task automatic test_start_during_busy();
    bit ok;
    char_mem[0] = 6'd9; char_mem[1] = 6'd2; char_mem[2] = 6'd3;
    launch(1, 8, 8);
    repeat (50) @(posedge clk);
    #1;
    len = 5'd3; dest_x = 10'd0; dest_y = 9'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, 1'b0, ok);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (seq_errs() !== 0) $display("FAIL busy_start_sequence: got %0d errors want 0", seq_errs());
    else n_pass++;
    n_checks++;
    if (done_cnt - db !== 1 || busy !== 1'b0) $display("FAIL busy_start_ignored: got %0d done pulses want 1", done_cnt - db);
    else n_pass++;
    n_checks++;
    if (done_cyc - busy_rise !== 193) $display("FAIL busy_start_timing: got %0d want 193", done_cyc - busy_rise);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    char_mem[0] = 6'd3;
    launch(1, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (fb_we && k > 40) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL rst_mid_no_write: got fb_we=0 want 1");
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, fb_we} !== 3'b000) $display("FAIL rst_mid_async: got %b want 000", {busy, done, fb_we});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ob = obs_q.size();
    db = done_cnt;
    repeat (300) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() - ob !== 0 || done_cnt - db !== 0 || busy !== 1'b0)
      $display("FAIL rst_mid_quiet: got %0d writes %0d dones want 0 0", obs_q.size() - ob, done_cnt - db);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) char_mem[i] = 6'd63;
    test_reset();
    test_single_s();
    test_spaces();
    test_random_ready();
    test_clip();
    test_len_edges();
    test_start_during_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_blit_engine.md
Name: text_blit_engine

Overview:
- Sequencer that renders a short string of 6-bit character codes into the framebuffer.
- Per character: computes the 8x8 glyph's sprite-sheet start address (same letter/number encoding as the font lookup), reads the glyph one pixel at a time from sprite ROM, and writes each pixel to the framebuffer through a ready/valid write port.
- Sits between game logic (score/label text) and the framebuffer arbiter.

Parameters:
- MAX_LEN, 16: maximum characters per string; char_idx is $clog2(MAX_LEN) bits.
- FB_WIDTH, 320: framebuffer width in pixels.
- FB_HEIGHT, 240: framebuffer height in pixels.
- PIX_W, 4: palette-index width of sprite and framebuffer pixels.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- len  in  5  string length, 0..MAX_LEN; values above MAX_LEN are clamped to MAX_LEN.
- dest_x  in  10  top-left x of the first glyph.
- dest_y  in  9  top-left y of the first glyph.
- busy  out  1  high from the cycle after start is accepted until the DONE state.
- done  out  1  one-cycle pulse at completion.
- char_idx  out  4  index of the character being requested.
- char_code  in  6  combinational reply to char_idx, valid in the same cycle.
- sprite_addr  out  20  sprite ROM read address.
- sprite_data  in  PIX_W  ROM data; valid exactly one cycle after sprite_addr.
- fb_addr  out  20  framebuffer word address.
- fb_data  out  PIX_W  pixel to write.
- fb_we  out  1  write valid.
- fb_ready  in  1  framebuffer accepts.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset asserted mid-string aborts immediately, with no further fb_we and no done pulse.
- IDLE: on start=1, latch len (clamped), dest_x and dest_y, clear char counter ci, go to CHAR. If len=0, go straight to DONE instead (no writes). start is ignored in every other state.
- CHAR (1 cycle): char_idx=ci; sample char_code.
  - Code 63 (space): no pixels. If ci is the last character go to DONE, else ci++ and stay in CHAR.
  - Code >35 and not 63: rendered as code 0 ('A').
  - Otherwise compute the glyph base, clear px/py (3 bits each), go to ADDR.
- Glyph base: 10272 + (code>>3)*1280 + (code&7)*8. The sheet is 160 px wide; row stride is 1280 = 8*160.
- ADDR (1 cycle): sprite_addr = base + py*160 + px; go to DATA.
- DATA (1 cycle): register sprite_data and compute:
  - x = dest_x + 8*ci + px, y = dest_y + py, both with 11-bit intermediates so there is no wrap.
  - Go to WRITE.
- WRITE:
  - If x>=FB_WIDTH or y>=FB_HEIGHT: fb_we stays 0 for exactly one cycle (clipped pixel).
  - Otherwise fb_we=1, fb_addr=y*FB_WIDTH+x, fb_data=pixel. All three are held stable until fb_ready=1; the transfer completes on the edge where fb_we&fb_ready.
  - After the pixel completes, advance px, then py, raster order.
  - After pixel (7,7): if ci is the last character go to DONE, else ci++ and go to CHAR. Otherwise go to ADDR.
- DONE (1 cycle): done=1, busy=0; return to IDLE. A start in that IDLE cycle is accepted normally.
- Timing, with fb_ready held 1: each non-space character takes exactly 193 cycles (1 CHAR + 64×(ADDR, DATA, WRITE)); each space takes 1 cycle.
- fb_we is never asserted outside WRITE. Only one write is outstanding at a time.

Optional Feature:
- Macro TEXT_BLIT_TRANSPARENT_EN.
- Defined: a pixel whose sprite_data==0 is treated like a clipped pixel. fb_we stays low and WRITE lasts exactly 1 cycle, so background shows through.
- Undefined: index-0 pixels are written like any other pixel.

Test Plan:
- Reset_n low mid-glyph with fb_we=1 -> busy/done/fb_we go 0 asynchronously; after release, no writes until the next start.
- len=1, code 18 ('S'), dest=(0,0), fb_ready=1 -> first sprite_addr 12848, 64 writes to fb_addr {0..7, 320..327, ..., 2240..2247}, done exactly 193 cycles after busy rises.
- len=3, codes {63,26,63}, dest=(100,50) -> only glyph '0' written (base 14128), first fb_addr 50*320+108=16108, busy for 1+193+1 cycles.
- fb_ready toggled pseudo-randomly -> fb_addr/fb_data stable while fb_we&!fb_ready, exactly 64 accepted writes, no duplicates.
- dest_x=316, len=1, code 0 -> only px 0..3 written per row (32 writes), timing still 193 cycles; code 40 renders identically to code 0.
- len=0 -> done pulses the cycle after start, no fb_we. start during busy -> ignored, pixel sequence unchanged.
